// File: rtl/alu_ctrl_decode_reg_if.sv
// rtl/alu_ctrl_decode_reg_if.sv - ID/EX decode bus between pipeline control and the ALU decode register
interface alu_ctrl_decode_reg_if;
    logic [31:0] Instruction;
    logic        InValid;
    logic        Stall;
    logic        Flush;
    logic [5:0]  ALUControl;
    logic        ASel;
    logic [1:0]  BSel;
    logic        OutValid;
    logic        Illegal;
    logic        IllegalSticky;

    modport master (
        output Instruction, InValid, Stall, Flush,
        input  ALUControl, ASel, BSel, OutValid, Illegal, IllegalSticky
    );

    modport slave (
        input  Instruction, InValid, Stall, Flush,
        output ALUControl, ASel, BSel, OutValid, Illegal, IllegalSticky
    );
endinterface

// File: rtl/alu_ctrl_decode_reg.sv
// rtl/alu_ctrl_decode_reg.sv - MIPS ALU control decode with registered ID/EX outputs
// Combinational decode of the IF/ID instruction, one-cycle registered with stall/flush/bubble control.
module alu_ctrl_decode_reg #(
    parameter logic [5:0] BUBBLE_CTRL = 6'b100000
) (
    input  logic                       Clk,
    input  logic                       Reset,
    alu_ctrl_decode_reg_if.slave       bus
);
    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rt;

    logic [5:0] dec_ctrl;
    logic       dec_asel;
    logic [1:0] dec_bsel;
    logic       dec_illegal;

    logic [5:0] ctrl_d, ctrl_q;
    logic       asel_d, asel_q;
    logic [1:0] bsel_d, bsel_q;
    logic       valid_d, valid_q;
    logic       illegal_d, illegal_q;
    logic       sticky_d, sticky_q;

    assign op    = bus.Instruction[31:26];
    assign funct = bus.Instruction[5:0];
    assign rt    = bus.Instruction[20:16];

    // Illegal paths simply leave the bubble defaults in place.
    always_comb begin
        dec_ctrl    = BUBBLE_CTRL;
        dec_asel    = 1'b0;
        dec_bsel    = 2'd0;
        dec_illegal = 1'b0;
        case (op)
            6'b000000: begin
                case (funct)
                    6'b100000, 6'b100010, 6'b100100, 6'b100101,
                    6'b100111, 6'b100110, 6'b101010, 6'b001000: dec_ctrl = funct;
                    6'b000000: begin
                        dec_ctrl = 6'b000000;
                        dec_asel = 1'b1;
                    end
                    6'b000010: begin
                        dec_ctrl = 6'b111111;
                        dec_asel = 1'b1;
                    end
                    default: dec_illegal = 1'b1;
                endcase
            end
            6'b011100: begin
                if (funct == 6'b000010) dec_ctrl = 6'b011000;
                else                    dec_illegal = 1'b1;
            end
            6'b001000, 6'b100011, 6'b101011, 6'b100000,
            6'b100001, 6'b101000, 6'b101001: begin
                dec_ctrl = 6'b100000;
                dec_bsel = 2'd1;
            end
            6'b001010: begin
                dec_ctrl = 6'b101010;
                dec_bsel = 2'd1;
            end
            6'b001100: begin
                dec_ctrl = 6'b100100;
                dec_bsel = 2'd2;
            end
            6'b001101: begin
                dec_ctrl = 6'b100101;
                dec_bsel = 2'd2;
            end
            6'b001110: begin
                dec_ctrl = 6'b100110;
                dec_bsel = 2'd2;
            end
            6'b000100, 6'b000101, 6'b000110, 6'b000111,
            6'b000010, 6'b000011: dec_ctrl = op;
            6'b000001: begin
                if (rt == 5'b00000 || rt == 5'b00001) begin
                    dec_ctrl = 6'b000001;
                    dec_bsel = 2'd3;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // Flush beats Stall; a held illegal keeps feeding the sticky flag harmlessly.
    always_comb begin
        ctrl_d    = ctrl_q;
        asel_d    = asel_q;
        bsel_d    = bsel_q;
        valid_d   = valid_q;
        illegal_d = illegal_q;
        sticky_d  = sticky_q | illegal_q;
        if (bus.Flush || (!bus.Stall && !bus.InValid)) begin
            ctrl_d    = BUBBLE_CTRL;
            asel_d    = 1'b0;
            bsel_d    = 2'd0;
            valid_d   = 1'b0;
            illegal_d = 1'b0;
        end else if (!bus.Stall) begin
            ctrl_d    = dec_ctrl;
            asel_d    = dec_asel;
            bsel_d    = dec_bsel;
            valid_d   = 1'b1;
            illegal_d = dec_illegal;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ctrl_q    <= BUBBLE_CTRL;
            asel_q    <= 1'b0;
            bsel_q    <= 2'd0;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
            sticky_q  <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            asel_q    <= asel_d;
            bsel_q    <= bsel_d;
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
            sticky_q  <= sticky_d;
        end
    end

    assign bus.ALUControl    = ctrl_q;
    assign bus.ASel          = asel_q;
    assign bus.BSel          = bsel_q;
    assign bus.OutValid      = valid_q;
    assign bus.Illegal       = illegal_q;
    assign bus.IllegalSticky = sticky_q;
endmodule

// File: tb/tb_alu_ctrl_decode_reg.sv
// tb/tb_alu_ctrl_decode_reg.sv - scoreboard bench for the ALU control decode register
module tb_alu_ctrl_decode_reg;
    localparam logic [5:0] BUB = 6'b100000;

    typedef struct packed {
        logic [31:0] ins;
        logic [5:0]  c;
        logic        a;
        logic [1:0]  b;
        logic        ill;
    } entry_t;

    typedef struct packed {
        logic [31:0] ins;
        logic        v;
        logic        st;
        logic        fl;
        logic        rs;
    } step_t;

    logic Clk;
    logic Reset;
    alu_ctrl_decode_reg_if dif();

    alu_ctrl_decode_reg #(.BUBBLE_CTRL(BUB)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (dif.slave)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    entry_t      tbl[$];
    logic [11:0] sb[$];
    int          checks = 0;
    int          errors = 0;

    // Reference state of the output registers
    logic [5:0] m_c = BUB;
    logic       m_a = 1'b0;
    logic [1:0] m_b = 2'd0;
    logic       m_ov = 1'b0;
    logic       m_ill = 1'b0;
    logic       m_sticky = 1'b0;

    task automatic build_table();
        tbl.push_back({32'h00221820, 6'b100000, 1'b0, 2'd0, 1'b0}); // add
        tbl.push_back({32'h00221822, 6'b100010, 1'b0, 2'd0, 1'b0}); // sub
        tbl.push_back({32'h00221824, 6'b100100, 1'b0, 2'd0, 1'b0}); // and
        tbl.push_back({32'h00221825, 6'b100101, 1'b0, 2'd0, 1'b0}); // or
        tbl.push_back({32'h00221827, 6'b100111, 1'b0, 2'd0, 1'b0}); // nor
        tbl.push_back({32'h00221826, 6'b100110, 1'b0, 2'd0, 1'b0}); // xor
        tbl.push_back({32'h0022182A, 6'b101010, 1'b0, 2'd0, 1'b0}); // slt
        tbl.push_back({32'h03E00008, 6'b001000, 1'b0, 2'd0, 1'b0}); // jr
        tbl.push_back({32'h00021080, 6'b000000, 1'b1, 2'd0, 1'b0}); // sll
        tbl.push_back({32'h00000000, 6'b000000, 1'b1, 2'd0, 1'b0}); // nop (sll)
        tbl.push_back({32'h00021082, 6'b111111, 1'b1, 2'd0, 1'b0}); // srl
        tbl.push_back({32'h70221802, 6'b011000, 1'b0, 2'd0, 1'b0}); // mul
        tbl.push_back({32'h70221800, BUB,       1'b0, 2'd0, 1'b1}); // op 011100 bad funct
        tbl.push_back({32'h20010005, 6'b100000, 1'b0, 2'd1, 1'b0}); // addi
        tbl.push_back({32'h8C010004, 6'b100000, 1'b0, 2'd1, 1'b0}); // lw
        tbl.push_back({32'hAC010004, 6'b100000, 1'b0, 2'd1, 1'b0}); // sw
        tbl.push_back({32'h80010004, 6'b100000, 1'b0, 2'd1, 1'b0}); // lb
        tbl.push_back({32'h84010004, 6'b100000, 1'b0, 2'd1, 1'b0}); // lh
        tbl.push_back({32'hA0010004, 6'b100000, 1'b0, 2'd1, 1'b0}); // sb
        tbl.push_back({32'hA4010004, 6'b100000, 1'b0, 2'd1, 1'b0}); // sh
        tbl.push_back({32'h2801FFFF, 6'b101010, 1'b0, 2'd1, 1'b0}); // slti
        tbl.push_back({32'h3001FFFF, 6'b100100, 1'b0, 2'd2, 1'b0}); // andi
        tbl.push_back({32'h3401FFFF, 6'b100101, 1'b0, 2'd2, 1'b0}); // ori
        tbl.push_back({32'h3801FFFF, 6'b100110, 1'b0, 2'd2, 1'b0}); // xori
        tbl.push_back({32'h10220003, 6'b000100, 1'b0, 2'd0, 1'b0}); // beq
        tbl.push_back({32'h14220003, 6'b000101, 1'b0, 2'd0, 1'b0}); // bne
        tbl.push_back({32'h18200003, 6'b000110, 1'b0, 2'd0, 1'b0}); // blez
        tbl.push_back({32'h1C200003, 6'b000111, 1'b0, 2'd0, 1'b0}); // bgtz
        tbl.push_back({32'h04200008, 6'b000001, 1'b0, 2'd3, 1'b0}); // bltz
        tbl.push_back({32'h04810008, 6'b000001, 1'b0, 2'd3, 1'b0}); // bgez
        tbl.push_back({32'h04420000, BUB,       1'b0, 2'd0, 1'b1}); // regimm rt=2
        tbl.push_back({32'h08000010, 6'b000010, 1'b0, 2'd0, 1'b0}); // j
        tbl.push_back({32'h0C000010, 6'b000011, 1'b0, 2'd0, 1'b0}); // jal
        tbl.push_back({32'hFC000000, BUB,       1'b0, 2'd0, 1'b1}); // op 111111
        tbl.push_back({32'h0000003F, BUB,       1'b0, 2'd0, 1'b1}); // R-type bad funct
    endtask

    // Drives one cycle's inputs and pushes what the registers must hold after the next edge.
    task automatic drive(input step_t s);
        logic [5:0] c;
        logic       a;
        logic [1:0] b;
        logic       il;
        logic       sticky_n;
        c = BUB; a = 1'b0; b = 2'd0; il = 1'b1;
        foreach (tbl[i]) begin
            if (tbl[i].ins == s.ins) begin
                c = tbl[i].c; a = tbl[i].a; b = tbl[i].b; il = tbl[i].ill;
            end
        end
        sticky_n = s.rs ? 1'b0 : (m_sticky | m_ill);
        if (s.rs || s.fl || (!s.st && !s.v)) begin
            m_c = BUB; m_a = 1'b0; m_b = 2'd0; m_ov = 1'b0; m_ill = 1'b0;
        end else if (!s.st) begin
            m_ov = 1'b1; m_ill = il;
            m_c = il ? BUB : c;
            m_a = il ? 1'b0 : a;
            m_b = il ? 2'd0 : b;
        end
        m_sticky = sticky_n;
        sb.push_back({m_c, m_a, m_b, m_ov, m_ill, m_sticky});
        dif.Instruction = s.ins;
        dif.InValid     = s.v;
        dif.Stall       = s.st;
        dif.Flush       = s.fl;
        Reset           = s.rs;
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic test_reset();
        step_t s[$];
        logic [11:0] got, exp;
        s.push_back({32'h00221820, 1'b1, 1'b0, 1'b0, 1'b1});
        s.push_back({32'hFC000000, 1'b1, 1'b1, 1'b1, 1'b1});
        s.push_back({32'h20010005, 1'b1, 1'b0, 1'b0, 1'b1});
        foreach (s[i]) begin
            drive(s[i]);
            got = {dif.ALUControl, dif.ASel, dif.BSel, dif.OutValid, dif.Illegal, dif.IllegalSticky};
            exp = sb.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL reset step %0d got=%b expected=%b", i, got, exp);
            end
        end
    endtask

    task automatic test_decode();
        logic [11:0] got, exp;
        foreach (tbl[i]) begin
            drive({tbl[i].ins, 1'b1, 1'b0, 1'b0, 1'b0});
            got = {dif.ALUControl, dif.ASel, dif.BSel, dif.OutValid, dif.Illegal, dif.IllegalSticky};
            exp = sb.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL decode ins=%h got=%b expected=%b", tbl[i].ins, got, exp);
            end
        end
    endtask

    task automatic test_stall_flush();
        step_t s[$];
        logic [11:0] got, exp;
        s.push_back({32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1}); // clear sticky
        s.push_back({32'h00221820, 1'b0, 1'b0, 1'b0, 1'b0}); // bubble on InValid=0
        s.push_back({32'h20010005, 1'b1, 1'b0, 1'b0, 1'b0}); // addi
        s.push_back({32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0});
        s.push_back({32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0});
        s.push_back({32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0});
        s.push_back({32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0}); // sll after release
        s.push_back({32'h00221820, 1'b1, 1'b1, 1'b1, 1'b0}); // flush+stall
        s.push_back({32'h00021082, 1'b1, 1'b0, 1'b0, 1'b0}); // srl
        s.push_back({32'h04810008, 1'b1, 1'b0, 1'b0, 1'b0}); // bgez
        s.push_back({32'h00221820, 1'b1, 1'b0, 1'b0, 1'b0}); // add
        s.push_back({32'h00221820, 1'b1, 1'b1, 1'b0, 1'b0}); // stall
        s.push_back({32'h00221820, 1'b1, 1'b1, 1'b0, 1'b1}); // reset mid-stall
        s.push_back({32'h3401FFFF, 1'b1, 1'b0, 1'b0, 1'b0}); // ori after reset
        foreach (s[i]) begin
            drive(s[i]);
            got = {dif.ALUControl, dif.ASel, dif.BSel, dif.OutValid, dif.Illegal, dif.IllegalSticky};
            exp = sb.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL stall_flush step %0d got=%b expected=%b", i, got, exp);
            end
        end
    endtask

    task automatic test_illegal_sticky();
        step_t s[$];
        logic [11:0] got, exp;
        s.push_back({32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1});
        s.push_back({32'hFC000000, 1'b1, 1'b0, 1'b0, 1'b0}); // Illegal=1
        s.push_back({32'h00221820, 1'b1, 1'b0, 1'b0, 1'b0}); // sticky rises
        s.push_back({32'h00221820, 1'b1, 1'b0, 1'b1, 1'b0}); // flush keeps sticky
        s.push_back({32'h04420000, 1'b1, 1'b0, 1'b0, 1'b0}); // bad regimm
        s.push_back({32'h04420000, 1'b1, 1'b1, 1'b0, 1'b0}); // stall holds Illegal
        s.push_back({32'h00221820, 1'b1, 1'b0, 1'b0, 1'b1}); // reset clears sticky
        s.push_back({32'h00221820, 1'b1, 1'b0, 1'b0, 1'b0});
        foreach (s[i]) begin
            drive(s[i]);
            got = {dif.ALUControl, dif.ASel, dif.BSel, dif.OutValid, dif.Illegal, dif.IllegalSticky};
            exp = sb.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL illegal_sticky step %0d got=%b expected=%b", i, got, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        step_t       s;
        logic [11:0] got, exp;
        for (int i = 0; i < 300; i++) begin
            s.ins = tbl[$urandom_range(0, tbl.size() - 1)].ins;
            s.v   = ($urandom % 4) != 0;
            s.st  = ($urandom % 4) == 0;
            s.fl  = ($urandom % 8) == 0;
            s.rs  = ($urandom % 40) == 0;
            drive(s);
            got = {dif.ALUControl, dif.ASel, dif.BSel, dif.OutValid, dif.Illegal, dif.IllegalSticky};
            exp = sb.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL back_to_back cycle %0d ins=%h got=%b expected=%b", i, s.ins, got, exp);
            end
        end
    endtask

    initial begin
        Reset           = 1'b1;
        dif.Instruction = 32'h0;
        dif.InValid     = 1'b0;
        dif.Stall       = 1'b0;
        dif.Flush       = 1'b0;
        build_table();
        test_reset();
        test_decode();
        test_stall_flush();
        test_illegal_sticky();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_ctrl_decode_reg.md
ALU_CTRL_DECODE_REG -- requirements
Module: alu_ctrl_decode_reg

Parameters
REQ-001 SHALL provide parameter BUBBLE_CTRL, default 6'b100000, meaning the ALUControl value driven during bubbles, reset and flush (ADD of zeros).

Interface
REQ-002 SHALL have Clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have Reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have Instruction, input, 32, the MIPS instruction from IF/ID.
REQ-005 SHALL have InValid, input, 1, meaning Instruction is a real instruction rather than a bubble.
REQ-006 SHALL have Stall, input, 1, meaning hold all registered outputs.
REQ-007 SHALL have Flush, input, 1, meaning load a bubble.
REQ-008 SHALL have ALUControl, output, 6, the registered ALU operation code for the EX stage.
REQ-009 SHALL have ASel, output, 1: 0 = rs register value, 1 = zero-extended shamt (Instruction[10:6]).
REQ-010 SHALL have BSel, output, 2: 0 = rt value, 1 = sign-extended imm, 2 = zero-extended imm, 3 = zero-extended rt field (Instruction[20:16]).
REQ-011 SHALL have OutValid, output, 1, meaning the registered outputs describe a real instruction.
REQ-012 SHALL have Illegal, output, 1, registered, meaning the current OutValid instruction did not decode.
REQ-013 SHALL have IllegalSticky, output, 1, set by any registered Illegal and cleared only by Reset.

Function
REQ-014 SHALL decode R-type (op 000000) by funct to ALUControl/ASel/BSel with BSel=0:
- add 100000→100000; sub 100010→100010; and 100100→100100; or 100101→100101; nor 100111→100111; xor 100110→100110; slt 101010→101010; jr 001000→001000.
- sll 000000→000000, ASel=1; srl 000010→111111, ASel=1.
REQ-015 SHALL decode mul (op 011100, funct 000010) to ALUControl 011000, BSel=0.
REQ-016 SHALL decode immediate ops to ALUControl 100000, BSel=1: addi 001000, lw 100011, sw 101011, lb 100000, lh 100001, sb 101000, sh 101001.
REQ-017 SHALL decode slti 001010→101010 (BSel=1), andi 001100→100100, ori 001101→100101, xori 001110→100110 (these three BSel=2).
REQ-018 SHALL decode beq 000100→000100 and bne 000101→000101 with BSel=0; blez 000110→000110 and bgtz 000111→000111 with BSel=0.
REQ-019 SHALL decode REGIMM (op 000001) with rt 00000 (bltz) or 00001 (bgez) to ALUControl 000001, BSel=3; any other rt SHALL be illegal.
REQ-020 SHALL decode j 000010→000010 and jal 000011→000011, ASel=0, BSel=0.
REQ-021 SHALL treat any other opcode/funct with InValid=1 as illegal: load BUBBLE_CTRL, ASel=0, BSel=0, OutValid=1, Illegal=1.
REQ-022 SHALL have latency of exactly one cycle: outputs reflect the Instruction sampled at the previous edge.
REQ-023 SHALL apply per-edge priority Reset > Flush > Stall > load.
REQ-024 On load with InValid=0, SHALL register a bubble: BUBBLE_CTRL, ASel=0, BSel=0, OutValid=0, Illegal=0.
REQ-025 On Flush (with or without Stall), SHALL register a bubble as in REQ-024.
REQ-026 On Stall without Flush, SHALL hold every output, including Illegal, unchanged.
REQ-027 SHALL set IllegalSticky on the edge after Illegal is first registered high; Stall and Flush SHALL NOT clear it.
REQ-028 Decode logic SHALL be purely combinational from Instruction; the only state SHALL be the output registers and IllegalSticky.

Reset
REQ-029 While Reset=1 at an edge, SHALL register ALUControl=BUBBLE_CTRL, ASel=0, BSel=0, OutValid=0, Illegal=0, IllegalSticky=0, regardless of Stall, Flush and InValid.
REQ-030 Reset asserted mid-stall SHALL discard the held instruction; the first load after Reset deasserts SHALL behave normally.

Verification
REQ-031 add: Instruction 0x00221820 with InValid=1, one edge → ALUControl=100000, ASel=0, BSel=0, OutValid=1, Illegal=0.
REQ-032 srl then bgez:
- 0x00021082 → ALUControl=111111, ASel=1.
- next edge 0x04810008 → ALUControl=000001, BSel=3.
REQ-033 addi 0x20010005 loaded, then Stall=1 for 3 edges while Instruction=0x00000000 → outputs stay 100000/BSel=1/OutValid=1; Stall drops → ALUControl=000000, ASel=1.
REQ-034 Flush=1 and Stall=1 together with Instruction=0x00221820 → OutValid=0, ALUControl=BUBBLE_CTRL.
REQ-035 Illegal 0xFC000000 with InValid=1 → Illegal=1 for one cycle; IllegalSticky=1 from the next edge, persisting through Flush until Reset=1 edge → 0.
REQ-036 REGIMM with rt=00010 (0x04420000) → Illegal=1, ALUControl=BUBBLE_CTRL.
